shreg_seq: RTL and testbench
============================

Name: shreg_seq

Overview:
- Command-driven, parametrised universal shift register: successor to the single-mode serial shift register.
- Adds parallel load and clear, left/right shift and rotate, and multi-step commands with a step counter.
- Adds a valid/ready command handshake, busy/done status and a clock-enable stall.
- Used as a serializer/deserializer and bit-field aligner between datapath blocks.

Parameters:
- W, 32: register width in bits; requires W > S and W % S == 0.
- S, 1: bits moved per shift step.
- CNT_W, 8: width of the step-count field; maximum command length is 2^CNT_W-1 steps.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- ce_i  input  1  step enable; when low in RUN, the step is stalled.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  command accepted when cmd_valid_i and cmd_ready_o are both high.
- cmd_op_i  input  3  opcode: 0 LOAD, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 CLEAR, 6/7 NOP.
- cmd_cnt_i  input  CNT_W  number of steps; ignored for LOAD/CLEAR/NOP.
- load_i  input  W  parallel load data for LOAD.
- sin_i  input  S  serial input for SHL/SHR.
- sout_o  output  S  last bits shifted or rotated out; registered.
- par_o  output  W  current register contents.
- busy_o  output  1  high in RUN.
- done_o  output  1  one-cycle pulse after each command completes.

Behaviour:
- Reset (async, active-high, dominant): register=0, sout_o=0, state=IDLE, done_o=0, busy_o=0, step counter=0. cmd_ready_o=1 after reset release.
- cmd_ready_o is 1 exactly in IDLE (combinational from state).
- States: IDLE and RUN. done_o is a registered pulse.
- IDLE, accept LOAD: register<=load_i at the accept edge; sout_o unchanged; done_o=1 in the next cycle.
- IDLE, accept CLEAR: register<=0 and sout_o<=0 at the accept edge; done_o next cycle.
- IDLE, accept NOP: no state change; done_o next cycle.
- IDLE, accept shift/rotate with cnt=0: no shift; done_o next cycle; stays IDLE.
- IDLE, accept shift/rotate with cnt=N>0: latch the op, counter<=N, go to RUN. No step occurs at the accept edge.
- RUN: on each edge with ce_i=1, perform one step and decrement the counter. With ce_i=0, hold everything.
- RUN completion: the step that takes the counter to 0 also moves the state to IDLE, and done_o=1 in the following cycle. With ce_i held high, done_o is high in cycle N+1 after the accept cycle.
- done_o and cmd_ready_o may be high together, so back-to-back commands are allowed.
- Step definitions, with R the register and H/L its top/bottom S bits:
  - SHL: {sout,R} <= {R, sin_i}.
  - SHR: {R,sout} <= {sin_i, R}.
  - ROL: R <= {R[W-S-1:0], H}; sout <= H.
  - ROR: R <= {L, R[W-1:S]}; sout <= L.
- sin_i is sampled at every step edge; it may change per step.
- cmd_* inputs are ignored outside IDLE. A held cmd_valid_i is accepted once IDLE is re-entered.
- Reset mid-RUN aborts the command; no done_o pulse is produced.

Optional Feature:
- Macro SHREG_SEQ_ABORT_EN.
- Defined: adds port abort_i (input, 1).
  - abort_i=1 in RUN ends the command at that edge; no step is performed; the register keeps its current value; state goes to IDLE; done_o pulses next cycle.
  - abort_i in IDLE is ignored.
  - abort_i has priority over ce_i.
- Undefined: no abort_i port; commands always run to completion.

Decomposition:
- Package shreg_seq_pkg: opcode constants OP_LOAD..OP_NOP, state encodings ST_IDLE/ST_RUN, opcode width 3.
- Sub-module shreg_step: purely combinational one-step shifter (inputs R, sin, op; outputs next R and next sout). Parameters W and S.
- Top level holds the FSM, counter and registers.

Test Plan:
- W=8, S=1, ce=1: LOAD 0xA5, then SHL cnt=3 with sin=1 -> par_o=0x2F, sout_o=1, done_o in cycle 4 after accept, busy_o high for 3 cycles.
- From 0xA5: ROR cnt=4 -> par_o=0x5A, sout_o=0. Then SHR cnt=2 with sin=0 -> par_o=0x16, sout_o=1.
- SHL cnt=2 with ce_i low for 3 cycles mid-run -> register frozen during the stall; completion delayed by 3 cycles; final value identical to the unstalled run.
- SHL cnt=0 and NOP -> par_o unchanged, done_o one cycle after accept, busy_o never high. Back-to-back LOAD then CLEAR -> two done pulses in consecutive cycles; par_o=0.
- rst_i asserted asynchronously mid-RUN (between clock edges) -> outputs are 0 immediately, no done_o, cmd_ready_o=1 after release.
- With SHREG_SEQ_ABORT_EN: ROL cnt=8 on 0x81, abort after 2 steps -> par_o=0x06, done_o next cycle.

Source files
------------

// File: rtl/shreg_seq_pkg.sv
// shreg_seq_pkg: shared opcodes, FSM states and helpers for shreg_seq.
// Used by shreg_step (one-step shifter) and shreg_seq (top-level sequencer).
package shreg_seq_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_LOAD  = 3'd0;
    localparam logic [OPW-1:0] OP_SHL   = 3'd1;
    localparam logic [OPW-1:0] OP_SHR   = 3'd2;
    localparam logic [OPW-1:0] OP_ROL   = 3'd3;
    localparam logic [OPW-1:0] OP_ROR   = 3'd4;
    localparam logic [OPW-1:0] OP_CLEAR = 3'd5;
    localparam logic [OPW-1:0] OP_NOP   = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True for the four multi-step opcodes (SHL, SHR, ROL, ROR).
    function automatic logic is_shift(input logic [OPW-1:0] op);
        return (op >= OP_SHL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/shreg_step.sv
// shreg_step: combinational single-step shift/rotate of a W-bit register.
// Ports: r/sin/sout_cur/op in; r_nxt/sout_nxt out (pass-through for non-shift ops).
module shreg_step
    import shreg_seq_pkg::*;
#(
    parameter int W = 32,
    parameter int S = 1
) (
    input  logic [W-1:0]   r,
    input  logic [S-1:0]   sin,
    input  logic [S-1:0]   sout_cur,
    input  logic [OPW-1:0] op,
    output logic [W-1:0]   r_nxt,
    output logic [S-1:0]   sout_nxt
);

    always_comb begin
        r_nxt    = r;
        sout_nxt = sout_cur;
        case (op)
            OP_SHL: begin
                r_nxt    = {r[W-S-1:0], sin};
                sout_nxt = r[W-1 -: S];
            end
            OP_SHR: begin
                r_nxt    = {sin, r[W-1:S]};
                sout_nxt = r[S-1:0];
            end
            OP_ROL: begin
                r_nxt    = {r[W-S-1:0], r[W-1 -: S]};
                sout_nxt = r[W-1 -: S];
            end
            OP_ROR: begin
                r_nxt    = {r[S-1:0], r[W-1:S]};
                sout_nxt = r[S-1:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shreg_seq.sv
// shreg_seq: command-driven universal shift register (load/clear/shift/rotate, N steps).
// Ports: clk_i, rst_i (async high), ce_i, cmd_* handshake, load_i, sin_i -> par_o, sout_o,
// busy_o, done_o. Optional abort_i when SHREG_SEQ_ABORT_EN is defined.
module shreg_seq
    import shreg_seq_pkg::*;
#(
    parameter int W     = 32,
    parameter int S     = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
`ifdef SHREG_SEQ_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [OPW-1:0]   cmd_op_i,
    input  logic [CNT_W-1:0] cmd_cnt_i,
    input  logic [W-1:0]     load_i,
    input  logic [S-1:0]     sin_i,
    output logic [S-1:0]     sout_o,
    output logic [W-1:0]     par_o,
    output logic             busy_o,
    output logic             done_o
);

    state_t             state_q, state_d;
    logic [W-1:0]       r_q, r_d;
    logic [S-1:0]       sout_q, sout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPW-1:0]     op_q, op_d;
    logic               done_q, done_d;
    logic [W-1:0]       step_r;
    logic [S-1:0]       step_sout;
    logic               accept;
    logic               abort;

`ifdef SHREG_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    shreg_step #(
        .W (W),
        .S (S)
    ) u_step (
        .r        (r_q),
        .sin      (sin_i),
        .sout_cur (sout_q),
        .op       (op_q),
        .r_nxt    (step_r),
        .sout_nxt (step_sout)
    );

    assign accept = cmd_valid_i && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        sout_d  = sout_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (1'b1)
                        cmd_op_i == OP_LOAD: begin
                            r_d    = load_i;
                            done_d = 1'b1;
                        end
                        cmd_op_i == OP_CLEAR: begin
                            r_d    = '0;
                            sout_d = '0;
                            done_d = 1'b1;
                        end
                        is_shift(cmd_op_i) && (cmd_cnt_i != '0): begin
                            op_d    = cmd_op_i;
                            cnt_d   = cmd_cnt_i;
                            state_d = ST_RUN;
                        end
                        // NOP and zero-length shifts complete immediately.
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (ce_i) begin
                    r_d    = step_r;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q    <= '0;
            sout_q <= '0;
            cnt_q  <= '0;
            op_q   <= OP_NOP;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            sout_q <= sout_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            done_q <= done_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_RUN);
    assign par_o       = r_q;
    assign sout_o      = sout_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_shreg_seq.sv
// tb_shreg_seq: self-checking bench for shreg_seq (W=8, S=1).
// Table vectors, hand sequences for stall/reset/abort, and a randomized model check.
module tb_shreg_seq;
    import shreg_seq_pkg::*;

    localparam int W     = 8;
    localparam int S     = 1;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             ce;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OPW-1:0]   cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [W-1:0]     load;
    logic [S-1:0]     sin;
    logic [S-1:0]     sout;
    logic [W-1:0]     par;
    logic             busy;
    logic             done;
`ifdef SHREG_SEQ_ABORT_EN
    logic             abort;
`endif

    int checks   = 0;
    int failures = 0;

    shreg_seq #(
        .W     (W),
        .S     (S),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ce_i        (ce),
`ifdef SHREG_SEQ_ABORT_EN
        .abort_i     (abort),
`endif
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_cnt_i   (cmd_cnt),
        .load_i      (load),
        .sin_i       (sin),
        .sout_o      (sout),
        .par_o       (par),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OPW-1:0] op;
        int             cnt;
        logic [W-1:0]   ld;
        logic           s;
        logic [W-1:0]   par;
        logic           sout;
    } vec_t;

    vec_t tbl[13];

    int m_r;
    int m_s;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Issue one command with ce held high and wait (bounded) for done.
    task automatic run_cmd(input logic [OPW-1:0] op, input int cnt,
                           input logic [W-1:0] ld, input logic s,
                           input string tag);
        int cyc;
        int busy_n;
        int exp_busy;
        cyc    = 1;
        busy_n = 0;
        chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt[CNT_W-1:0];
        load      = ld;
        sin       = s;
        tick();
        cmd_valid = 1'b0;
        while (done !== 1'b1 && cyc < 400) begin
            if (busy === 1'b1) busy_n++;
            tick();
            cyc++;
        end
        exp_busy = (is_shift(op) && cnt > 0) ? cnt : 0;
        chk({tag, " latency"}, 32'(cyc), 32'(exp_busy + 1));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
    endtask

    // Reference step computed arithmetically on the integer model.
    task automatic model_step(input logic [OPW-1:0] op, input int b);
        int top;
        int bot;
        top = (m_r >> (W - 1)) & 1;
        bot = m_r & 1;
        case (op)
            OP_SHL: begin m_s = top; m_r = ((m_r << 1) | b) & 8'hFF; end
            OP_SHR: begin m_s = bot; m_r = (m_r >> 1) | (b << (W - 1)); end
            OP_ROL: begin m_s = top; m_r = ((m_r << 1) | top) & 8'hFF; end
            OP_ROR: begin m_s = bot; m_r = (m_r >> 1) | (bot << (W - 1)); end
            default: ;
        endcase
    endtask

    task automatic rand_cmd(input int idx);
        logic [OPW-1:0] op;
        int             cnt;
        logic [W-1:0]   ld;
        int             b;
        int             st;
        string          tag;
        tag = $sformatf("rnd%0d", idx);
        op  = OPW'($urandom_range(0, 7));
        cnt = $urandom_range(0, 6);
        ld  = W'($urandom);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt[CNT_W-1:0];
        load      = ld;
        sin       = S'($urandom);
        ce        = 1'b1;
        tick();
        cmd_valid = 1'b0;
        if (op == OP_LOAD) m_r = int'(ld);
        if (op == OP_CLEAR) begin m_r = 0; m_s = 0; end
        if (!(is_shift(op) && cnt > 0)) begin
            chk({tag, " done"}, 32'(done), 32'd1);
            chk({tag, " busy"}, 32'(busy), 32'd0);
        end else begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            for (int k = 0; k < cnt; k++) begin
                st = $urandom_range(0, 2);
                repeat (st) begin
                    // Junk command while running must be ignored.
                    cmd_valid = 1'b1;
                    cmd_op    = OP_LOAD;
                    load      = W'($urandom);
                    ce        = 1'b0;
                    sin       = S'($urandom);
                    tick();
                    chk({tag, " stall hold"}, 32'(par), 32'(m_r));
                end
                b   = $urandom_range(0, 1);
                sin = S'(b);
                ce  = 1'b1;
                tick();
                model_step(op, b);
                if (k < cnt - 1) begin
                    chk({tag, " mid done"}, 32'(done), 32'd0);
                end else begin
                    chk({tag, " done"}, 32'(done), 32'd1);
                end
            end
            cmd_valid = 1'b0;
        end
        chk({tag, " par"}, 32'(par), 32'(m_r));
        chk({tag, " sout"}, 32'(sout), 32'(m_s));
    endtask

    initial begin
        rst       = 1'b1;
        ce        = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_cnt   = '0;
        load      = '0;
        sin       = '0;
`ifdef SHREG_SEQ_ABORT_EN
        abort     = 1'b0;
`endif

        tbl[0]  = '{OP_LOAD,  0, 8'hA5, 1'b0, 8'hA5, 1'b0};
        tbl[1]  = '{OP_SHL,   3, 8'h00, 1'b1, 8'h2F, 1'b1};
        tbl[2]  = '{OP_LOAD,  0, 8'hA5, 1'b0, 8'hA5, 1'b1};
        tbl[3]  = '{OP_ROR,   4, 8'h00, 1'b0, 8'h5A, 1'b0};
        tbl[4]  = '{OP_SHR,   2, 8'h00, 1'b0, 8'h16, 1'b1};
        tbl[5]  = '{OP_ROL,   0, 8'h00, 1'b0, 8'h16, 1'b1};
        tbl[6]  = '{OP_NOP,   5, 8'hFF, 1'b1, 8'h16, 1'b1};
        tbl[7]  = '{OP_CLEAR, 0, 8'hFF, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{OP_LOAD,  0, 8'h81, 1'b0, 8'h81, 1'b0};
        tbl[9]  = '{OP_ROL,   1, 8'h00, 1'b0, 8'h03, 1'b1};
        tbl[10] = '{OP_SHR,   8, 8'h00, 1'b1, 8'hFF, 1'b0};
        tbl[11] = '{3'd7,     3, 8'h00, 1'b0, 8'hFF, 1'b0};
        tbl[12] = '{OP_SHL,   4, 8'h00, 1'b0, 8'hF0, 1'b1};

        #2;
        chk("rst par", 32'(par), 32'd0);
        chk("rst sout", 32'(sout), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        #10;
        rst = 1'b0;
        tick();
        chk("rst ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].ld, tbl[i].s,
                    $sformatf("vec%0d", i));
            chk($sformatf("vec%0d par", i), 32'(par), 32'(tbl[i].par));
            chk($sformatf("vec%0d sout", i), 32'(sout), 32'(tbl[i].sout));
        end

        // Stall: SHL 2 with ce low for 3 cycles between the steps.
        run_cmd(OP_LOAD, 0, 8'hA5, 1'b0, "stall load");
        cmd_valid = 1'b1;
        cmd_op    = OP_SHL;
        cmd_cnt   = 8'd2;
        sin       = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("stall step1", 32'(par), 32'h4B);
        ce = 1'b0;
        repeat (3) begin
            tick();
            chk("stall frozen", 32'(par), 32'h4B);
            chk("stall busy", 32'(busy), 32'd1);
            chk("stall no done", 32'(done), 32'd0);
        end
        ce = 1'b1;
        tick();
        chk("stall par", 32'(par), 32'h97);
        chk("stall sout", 32'(sout), 32'd0);
        chk("stall done", 32'(done), 32'd1);

        // Back-to-back LOAD then CLEAR.
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        load      = 8'h77;
        tick();
        chk("b2b load done", 32'(done), 32'd1);
        chk("b2b load par", 32'(par), 32'h77);
        cmd_op = OP_CLEAR;
        tick();
        chk("b2b clear done", 32'(done), 32'd1);
        chk("b2b clear par", 32'(par), 32'd0);
        chk("b2b clear sout", 32'(sout), 32'd0);
        cmd_valid = 1'b0;
        tick();
        chk("b2b idle done", 32'(done), 32'd0);

        m_r = 0;
        m_s = 0;
        for (int i = 0; i < 40; i++) begin
            rand_cmd(i);
        end
        cmd_valid = 1'b0;
        ce        = 1'b1;

        // Asynchronous reset in the middle of a run.
        run_cmd(OP_LOAD, 0, 8'h3C, 1'b0, "mrst load");
        cmd_valid = 1'b1;
        cmd_op    = OP_SHL;
        cmd_cnt   = 8'd5;
        sin       = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst par", 32'(par), 32'd0);
        chk("mrst sout", 32'(sout), 32'd0);
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst done", 32'(done), 32'd0);
        #3;
        rst = 1'b0;
        tick();
        chk("mrst ready", 32'(cmd_ready), 32'd1);
        chk("mrst no done", 32'(done), 32'd0);
        tick();
        chk("mrst no done2", 32'(done), 32'd0);

`ifdef SHREG_SEQ_ABORT_EN
        run_cmd(OP_LOAD, 0, 8'h81, 1'b0, "abort load");
        cmd_valid = 1'b1;
        cmd_op    = OP_ROL;
        cmd_cnt   = 8'd8;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort par", 32'(par), 32'h06);
        chk("abort done", 32'(done), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
